// File: rtl/booth_radix2_multiplier_if.sv
// Operand, control and result bundle for the Booth radix-2 multiplier.
// The master drives start and the operands; the slave returns the product and status.
interface booth_radix2_multiplier_if #(
    parameter int N = 16
);
    logic           start;
    logic [N-1:0]   data_m;
    logic [N-1:0]   data_q;
    logic [2*N-1:0] product;
    logic           done;
    logic           busy;
    logic [2:0]     state;

    modport master (
        output start, data_m, data_q,
        input  product, done, busy, state
    );

    modport slave (
        input  start, data_m, data_q,
        output product, done, busy, state
    );
endinterface

// File: rtl/booth_radix2_multiplier.sv
// Sequential signed multiplier using radix-2 Booth recoding: one add/sub (optional)
// followed by one arithmetic shift per multiplier bit, sequenced by a small FSM.
module booth_radix2_multiplier #(
    parameter int N = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    booth_radix2_multiplier_if.slave    bus
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_LOAD_M = 3'b001,
        S_LOAD_Q = 3'b010,
        S_CHECK  = 3'b011,
        S_ADDSUB = 3'b100,
        S_SHIFT  = 3'b101,
        S_DONE   = 3'b110
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N:0]      r_a;
    logic [N-1:0]    r_q;
    logic            r_qm1;
    logic [N:0]      r_m;
    logic [CW-1:0]   r_count;
    logic            r_sub;
    logic [CW-1:0]   w_count_dec;
    logic            w_done;
    logic            w_busy;

    assign w_count_dec = r_count - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_LOAD_M;
            S_LOAD_M: w_next = S_LOAD_Q;
            S_LOAD_Q: w_next = S_CHECK;
            // Booth pair 10 subtracts M, 01 adds M; equal bits skip straight to the shift.
            S_CHECK:  w_next = (r_q[0] ^ r_qm1) ? S_ADDSUB : S_SHIFT;
            S_ADDSUB: w_next = S_SHIFT;
            S_SHIFT:  w_next = (w_count_dec == '0) ? S_DONE : S_CHECK;
            S_DONE:   if (bus.start) w_next = S_LOAD_M;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_done = (r_state == S_DONE);
        w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
    end

    // Datapath: A carries one guard bit so that M = -2^(N-1) negates without overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_m     <= '0;
            r_count <= '0;
            r_sub   <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD_M: r_m <= {bus.data_m[N-1], bus.data_m};
                S_LOAD_Q: begin
                    r_q     <= bus.data_q;
                    r_a     <= '0;
                    r_qm1   <= 1'b0;
                    r_count <= CW'(N);
                end
                S_CHECK:  r_sub <= r_q[0] & ~r_qm1;
                S_ADDSUB: r_a <= r_sub ? (r_a - r_m) : (r_a + r_m);
                S_SHIFT: begin
                    {r_a, r_q, r_qm1} <= {r_a[N], r_a, r_q};
                    r_count           <= w_count_dec;
                end
                default: ;
            endcase
        end
    end

    assign bus.product = {r_a[N-1:0], r_q};
    assign bus.done    = w_done;
    assign bus.busy    = w_busy;
    assign bus.state   = r_state;
endmodule

// File: tb/tb_booth_radix2_multiplier.sv
// Self-checking bench for booth_radix2_multiplier (N=16) using a product scoreboard.
module tb_booth_radix2_multiplier;
    localparam int N = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [2*N-1:0] exp_q[$];

    booth_radix2_multiplier_if #(.N(N)) bus ();

    booth_radix2_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one operation (caller sits 1 time unit after a rising edge) and wait for done.
    // cycles counts rising edges after the start-sampling edge until done is seen.
    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                          input logic [2*N-1:0] exp, input bit push,
                          output int cycles, output int n_s4,
                          output bit saw_loop, output bit done_after_start);
        bit saw3;
        bit saw5;
        saw3 = 0;
        saw5 = 0;
        n_s4 = 0;
        cycles = 0;
        bus.start  = 1'b1;
        bus.data_m = m;
        bus.data_q = q;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_after_start = bus.done;
        while (1) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 2) begin
                bus.data_m = N'($urandom_range(0, 65535));
                bus.data_q = N'($urandom_range(0, 65535));
            end
            if (bus.state == 3'b011) saw3 = 1;
            if (bus.state == 3'b100) n_s4++;
            if (bus.state == 3'b101) saw5 = 1;
            if (bus.done || cycles >= 200) break;
        end
        saw_loop = saw3 && saw5;
        if (!bus.done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: done not seen after %0d cycles (m=%h q=%h)", cycles, m, q);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start  = 1'b0;
        bus.data_m = '0;
        bus.data_q = '0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.state !== 3'b000) begin n_fail++; $display("FAIL reset_state: got %b want 000", bus.state); end
        n_tests++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++;
        if (bus.product !== 32'h0) begin n_fail++; $display("FAIL reset_product: got %h want 0", bus.product); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.state !== 3'b000) begin n_fail++; $display("FAIL idle_hold: got %b want 000", bus.state); end
    endtask

    task automatic test_basic();
        int cyc, s4;
        bit loop_seen, d0;
        logic [2*N-1:0] e;
        run_op(16'hFFF3, 16'd10, 32'hFFFFFF7E, 1, cyc, s4, loop_seen, d0);
        e = exp_q.pop_front();
        n_tests++;
        if (bus.product !== e) begin n_fail++; $display("FAIL basic_product: got %h want %h", bus.product, e); end
        n_tests++;
        if (!(loop_seen && s4 > 0)) begin n_fail++; $display("FAIL basic_trace: loop=%0d s4=%0d want loop=1 s4>0", loop_seen, s4); end
        n_tests++;
        if (bus.state !== 3'b110) begin n_fail++; $display("FAIL basic_state: got %b want 110", bus.state); end
        // 10 = 0b1010 has four Booth transitions, each adding one cycle.
        n_tests++;
        if (cyc != 38) begin n_fail++; $display("FAIL basic_latency: got %0d want 38", cyc); end
        // DONE must hold the result while start stays low.
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus.done !== 1'b1 || bus.product !== e) begin
            n_fail++;
            $display("FAIL basic_hold: done=%b product=%h want done=1 product=%h", bus.done, bus.product, e);
        end
    endtask

    task automatic test_zero();
        int cyc, s4;
        bit loop_seen, d0;
        logic [2*N-1:0] e;
        run_op(16'd7, 16'd0, 32'h0, 1, cyc, s4, loop_seen, d0);
        e = exp_q.pop_front();
        n_tests++;
        if (bus.product !== e) begin n_fail++; $display("FAIL zero_product: got %h want %h", bus.product, e); end
        n_tests++;
        if (cyc != 34) begin n_fail++; $display("FAIL zero_latency: got %0d want 34", cyc); end
        n_tests++;
        if (s4 != 0) begin n_fail++; $display("FAIL zero_no_addsub: got %0d S4 visits want 0", s4); end
    endtask

    task automatic test_corners();
        logic [N-1:0]   tm [4];
        logic [N-1:0]   tq [4];
        logic [2*N-1:0] te [4];
        int cyc, s4;
        bit loop_seen, d0;
        logic [2*N-1:0] e;
        tm = '{16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF};
        tq = '{16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF};
        te = '{32'h40000000, 32'hFFFF8000, 32'hFFFF8001, 32'h00000001};
        for (int i = 0; i < 4; i++) begin
            run_op(tm[i], tq[i], te[i], 1, cyc, s4, loop_seen, d0);
            e = exp_q.pop_front();
            n_tests++;
            if (bus.product !== e) begin
                n_fail++;
                $display("FAIL corner_%0d: m=%h q=%h got %h want %h", i, tm[i], tq[i], bus.product, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int cyc, s4;
        bit loop_seen, d0;
        logic [2*N-1:0] e;
        bus.start  = 1'b1;
        bus.data_m = 16'd100;
        bus.data_q = 16'hB3B3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        guard = 0;
        while (bus.state !== 3'b100 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_tests++;
        if (bus.state !== 3'b100) begin n_fail++; $display("FAIL midreset_reach_s4: got %b want 100", bus.state); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (bus.state !== 3'b000 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: state=%b done=%b busy=%b product=%h want 000/0/0/0",
                     bus.state, bus.done, bus.busy, bus.product);
        end
        run_op(16'd5, 16'd6, 32'd30, 1, cyc, s4, loop_seen, d0);
        e = exp_q.pop_front();
        n_tests++;
        if (bus.product !== e) begin n_fail++; $display("FAIL midreset_after: got %h want %h", bus.product, e); end
    endtask

    task automatic test_back_to_back();
        int cyc, s4;
        bit loop_seen, d0;
        logic [2*N-1:0] e;
        n_tests++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_precondition_done: got %b want 1", bus.done); end
        run_op(16'd3, 16'hFFFC, 32'hFFFFFFF4, 1, cyc, s4, loop_seen, d0);
        e = exp_q.pop_front();
        n_tests++;
        if (d0 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b want 0", d0); end
        n_tests++;
        if (bus.product !== e) begin n_fail++; $display("FAIL b2b_product: got %h want %h", bus.product, e); end
        // 0xFFFC has one Booth transition (bit 2).
        n_tests++;
        if (cyc != 35) begin n_fail++; $display("FAIL b2b_latency: got %0d want 35", cyc); end
    endtask

    task automatic test_random();
        int cyc, s4, trans, exp_cyc;
        bit loop_seen, d0;
        logic [N-1:0] m, q;
        logic [2*N-1:0] model, e;
        bit prev;
        for (int k = 0; k < 8; k++) begin
            m = N'($urandom_range(0, 65535));
            q = N'($urandom_range(0, 65535));
            model = $signed(m) * $signed(q);
            trans = 0;
            prev = 1'b0;
            for (int b = 0; b < N; b++) begin
                if (q[b] != prev) trans++;
                prev = q[b];
            end
            exp_cyc = 2 + 2 * N + trans;
            run_op(m, q, model, 1, cyc, s4, loop_seen, d0);
            e = exp_q.pop_front();
            n_tests++;
            if (bus.product !== e) begin
                n_fail++;
                $display("FAIL random_%0d: m=%h q=%h got %h want %h", k, m, q, bus.product, e);
            end
            n_tests++;
            if (cyc != exp_cyc) begin
                n_fail++;
                $display("FAIL random_latency_%0d: q=%h got %0d want %0d", k, q, cyc, exp_cyc);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_zero();
        test_corners();
        test_reset_mid();
        test_back_to_back();
        test_random();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries remain want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
